// File: rtl/oled_glyph_streamer.sv
// Fetches an 8x8 glyph from a combinational font ROM and streams its 8 column bytes to the OLED serializer.
// First byte is valid 2 cycles after the character handshake; byte_ready low holds the current byte, and no character is accepted while busy.
module oled_glyph_streamer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_data,
  input  logic        char_inv,
  output logic [7:0]  rom_addr,
  input  logic [63:0] rom_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        busy,
  output logic        glyph_done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rom_addr_q, rom_addr_d;
  logic        inv_q, inv_d;
  logic [63:0] glyph_q, glyph_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [2:0]  byte_sel;
  logic [5:0]  bit_base;

  // Byte 0 sits at the top of the ROM word when MSB_FIRST is set, so the counter is mirrored.
  assign byte_sel   = MSB_FIRST ? ~cnt_q : cnt_q;
  assign bit_base   = {byte_sel, 3'b000};
  assign rom_addr   = rom_addr_q;
  assign glyph_done = done_q;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    inv_d      = inv_q;
    glyph_d    = glyph_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    char_ready = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy       = 1'b0;
        char_ready = ~rst;
        if (char_valid && !rst) begin
          // Codes above 0x7F have no glyph; show the checkerboard instead.
          rom_addr_d = char_data[7] ? 8'h7F : char_data;
          inv_d      = char_inv;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        glyph_d = rom_data ^ {64{inv_q}};
        cnt_d   = 3'd0;
        state_d = SEND;
      end
      SEND: begin
        byte_valid = 1'b1;
        byte_data  = glyph_q[bit_base +: 8];
        if (byte_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= 8'h00;
      inv_q      <= 1'b0;
      glyph_q    <= 64'h0;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      inv_q      <= inv_d;
      glyph_q    <= glyph_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

endmodule
